twiddle_cmul: RTL and testbench

- Sequential complex twiddle multiplier for the FFT datapath; sits directly downstream of the butterfly adders and feeds the next radix-2 stage.
- Computes Y = X·W for a complex sample X and twiddle W using one time-shared shift-add real multiplier over four partial products.
- Rescales the result back to WIDTH bits with rounding and saturation.
- Valid/ready handshake on both sides; one transaction in flight.

---
 rtl/twiddle_cmul_if.sv | 27 ++
 rtl/twiddle_cmul.sv | 189 ++++++++++++++++++
 tb/tb_twiddle_cmul.sv | 138 +++++++++++++
 3 files changed

// File: rtl/twiddle_cmul_if.sv
// Operand/result handshake bundle for the twiddle multiplier.
// Upstream drives the master side; the multiplier sits on the slave side.
interface twiddle_cmul_if #(
   parameter int WIDTH = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] xr;
   logic signed [WIDTH-1:0] xi;
   logic signed [WIDTH-1:0] wr;
   logic signed [WIDTH-1:0] wi;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] yr;
   logic signed [WIDTH-1:0] yi;
   logic                    ovf;

   modport master (
      output in_valid, xr, xi, wr, wi, out_ready,
      input  in_ready, out_valid, yr, yi, ovf
   );

   modport slave (
      input  in_valid, xr, xi, wr, wi, out_ready,
      output in_ready, out_valid, yr, yi, ovf
   );
endinterface

// File: rtl/twiddle_cmul.sv
// Sequential complex multiply Y = X*W on one shared shift-add multiplier,
// four partial products, round-half-up and saturate back to WIDTH bits.
module twiddle_cmul #(
   parameter int WIDTH = 8
) (
   input  logic          clkin,
   input  logic          rst_n,
   twiddle_cmul_if.slave bus
);

   localparam int AW = 2*WIDTH + 1;
   localparam int PW = 2*WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic signed [AW:0] RND  = (AW+1)'(1 << (WIDTH-2));
   localparam logic signed [AW:0] SMAX = (AW+1)'((1 << (WIDTH-1)) - 1);
   localparam logic signed [AW:0] SMIN = ~SMAX;

   typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, ROUND, OUT} state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] xr_q, xr_d, xi_q, xi_d, wr_q, wr_d, wi_q, wi_d;
   logic signed [AW-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic [1:0]              idx_q, idx_d;
   logic [PW-1:0]           mcand_q, mcand_d, pp_q, pp_d;
   logic [WIDTH-1:0]        mplier_q, mplier_d;
   logic                    psign_q, psign_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic signed [WIDTH-1:0] yr_q, yr_d, yi_q, yi_d;
   logic                    ovf_q, ovf_d;
   logic                    out_valid_q, out_valid_d;

   logic signed [WIDTH-1:0] opa, opb;
   logic signed [AW-1:0]    prod_s;
   logic [WIDTH:0]          rre, rim;

   // Magnitude as unsigned WIDTH bits: the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   // Returns {clip, value}.
   function automatic logic [WIDTH:0] rnd_sat(input logic signed [AW-1:0] a);
      logic signed [AW:0] s;
      s = $signed({a[AW-1], a}) + RND;
      s = s >>> (WIDTH-1);
      if (s > SMAX)      return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      else if (s < SMIN) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else               return {1'b0, s[WIDTH-1:0]};
   endfunction

   always_comb begin
      opa = xr_q;
      opb = wr_q;
      case (idx_q)
         2'd0: begin opa = xr_q; opb = wr_q; end
         2'd1: begin opa = xi_q; opb = wi_q; end
         2'd2: begin opa = xr_q; opb = wi_q; end
         default: begin opa = xi_q; opb = wr_q; end
      endcase
   end

   assign prod_s = psign_q ? -$signed({1'b0, pp_q}) : $signed({1'b0, pp_q});
   assign rre    = rnd_sat(acc_re_q);
   assign rim    = rnd_sat(acc_im_q);

   always_comb begin
      state_d     = state_q;
      xr_d        = xr_q;
      xi_d        = xi_q;
      wr_d        = wr_q;
      wi_d        = wi_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      idx_d       = idx_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      pp_d        = pp_q;
      psign_d     = psign_q;
      cnt_d       = cnt_q;
      yr_d        = yr_q;
      yi_d        = yi_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               xr_d     = bus.xr;
               xi_d     = bus.xi;
               wr_d     = bus.wr;
               wi_d     = bus.wi;
               acc_re_d = '0;
               acc_im_d = '0;
               idx_d    = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            mcand_d  = {{WIDTH{1'b0}}, mag(opa)};
            mplier_d = mag(opb);
            psign_d  = opa[WIDTH-1] ^ opb[WIDTH-1];
            pp_d     = '0;
            cnt_d    = '0;
            state_d  = MUL;
         end
         MUL: begin
            // Always WIDTH iterations so latency does not depend on data.
            if (mplier_q[0]) pp_d = pp_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CW'(WIDTH-1)) state_d = ACC;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         ACC: begin
            case (idx_q)
               2'd0:    acc_re_d = acc_re_q + prod_s;
               2'd1:    acc_re_d = acc_re_q - prod_s;
               default: acc_im_d = acc_im_q + prod_s;
            endcase
            if (idx_q == 2'd3) state_d = ROUND;
            else begin
               idx_d   = idx_q + 1'b1;
               state_d = LOAD;
            end
         end
         ROUND: begin
            yr_d        = rre[WIDTH-1:0];
            yi_d        = rim[WIDTH-1:0];
            ovf_d       = rre[WIDTH] | rim[WIDTH];
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         xr_q        <= '0;
         xi_q        <= '0;
         wr_q        <= '0;
         wi_q        <= '0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         idx_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         pp_q        <= '0;
         psign_q     <= 1'b0;
         cnt_q       <= '0;
         yr_q        <= '0;
         yi_q        <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         xr_q        <= xr_d;
         xi_q        <= xi_d;
         wr_q        <= wr_d;
         wi_q        <= wi_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         idx_q       <= idx_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         pp_q        <= pp_d;
         psign_q     <= psign_d;
         cnt_q       <= cnt_d;
         yr_q        <= yr_d;
         yi_q        <= yi_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && rst_n;
   assign bus.out_valid = out_valid_q;
   assign bus.yr        = yr_q;
   assign bus.yi        = yi_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_twiddle_cmul.sv
// Scoreboard bench for twiddle_cmul: integer reference model, fixed-latency,
// backpressure and mid-operation reset checks.
module tb_twiddle_cmul;
   localparam int W   = 8;
   localparam int LAT = 4*(W+2) + 1;

   logic clkin = 1'b0;
   logic rst_n = 1'b0;
   always #5 clkin = ~clkin;

   twiddle_cmul_if #(.WIDTH(W)) bus();
   twiddle_cmul #(.WIDTH(W)) dut (.clkin(clkin), .rst_n(rst_n), .bus(bus));

   typedef struct {int yr; int yi; int ovf;} exp_t;
   exp_t sb[$];
   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Floor division by 2^(W-1) after adding half an LSB, then clip.
   function automatic int fix(input int v, output int clip);
      int s, d, r;
      s = v + (1 << (W-2));
      d = 1 << (W-1);
      r = (s >= 0) ? s / d : -((-s + d - 1) / d);
      clip = 0;
      if (r > d - 1) begin r = d - 1; clip = 1; end
      if (r < -d)    begin r = -d;    clip = 1; end
      return r;
   endfunction

   function automatic exp_t model(input int a, input int b, input int c, input int d);
      exp_t e;
      int c1, c2;
      e.yr  = fix(a*c - b*d, c1);
      e.yi  = fix(a*d + b*c, c2);
      e.ovf = c1 | c2;
      return e;
   endfunction

   task automatic run(input int a, input int b, input int c, input int d, input int bp);
      exp_t e;
      int lat;
      logic signed [W-1:0] hr, hi;
      logic ho;
      sb.push_back(model(a, b, c, d));
      @(negedge clkin);
      chk("in_ready_idle", bus.in_ready, 1);
      bus.xr = W'(a); bus.xi = W'(b); bus.wr = W'(c); bus.wi = W'(d);
      bus.in_valid = 1'b1;
      @(posedge clkin); #1;
      bus.in_valid = 1'b0;
      chk("in_ready_busy", bus.in_ready, 0);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         bus.xr = W'($urandom); bus.xi = W'($urandom);
         bus.wr = W'($urandom); bus.wi = W'($urandom);
         @(posedge clkin); #1;
         lat++;
      end
      chk("latency", lat, LAT);
      e = sb.pop_front();
      chk("yr", bus.yr, e.yr);
      chk("yi", bus.yi, e.yi);
      chk("ovf", bus.ovf, e.ovf);
      hr = bus.yr; hi = bus.yi; ho = bus.ovf;
      for (int k = 0; k < bp; k++) begin
         @(posedge clkin); #1;
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_yr", bus.yr, hr);
         chk("bp_yi", bus.yi, hi);
         chk("bp_ovf", bus.ovf, ho);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clkin); #1;
      bus.out_ready = 1'b0;
      chk("out_valid_clr", bus.out_valid, 0);
      chk("in_ready_back", bus.in_ready, 1);
      chk("yr_retained", bus.yr, hr);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.xr = '0; bus.xi = '0; bus.wr = '0; bus.wi = '0;
      repeat (3) @(posedge clkin);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_yr", bus.yr, 0);
      chk("rst_yi", bus.yi, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      @(negedge clkin);
      rst_n = 1'b1;

      run(64, 0, 64, 0, 0);
      run(64, 32, 0, -128, 0);
      run(-128, 0, -128, 0, 0);
      run(-128, 0, 127, 0, 0);
      run(1, 0, 64, 0, 0);
      run(-1, 0, 64, 0, 0);
      run(100, -50, 90, 30, 10);

      // Abort in the middle of the xr*wi product; the held result above is nonzero.
      @(negedge clkin);
      bus.xr = 8'sd100; bus.xi = 8'sd100; bus.wr = 8'sd100; bus.wi = 8'sd100;
      bus.in_valid = 1'b1;
      @(posedge clkin); #1;
      bus.in_valid = 1'b0;
      repeat (24) @(posedge clkin);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_yr", bus.yr, 0);
      chk("abort_yi", bus.yi, 0);
      chk("abort_ovf", bus.ovf, 0);
      chk("abort_in_ready", bus.in_ready, 0);
      @(negedge clkin);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      run(64, 0, 64, 0, 0);

      for (int n = 0; n < 8; n++)
         run(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, n % 3);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
